// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - register file with pending-write scoreboard and clear sweep
module reg_file_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [AW-1:0]   RADDR1,
    input  logic [AW-1:0]   RADDR2,
    output logic [XLEN-1:0] RDATA1,
    output logic [XLEN-1:0] RDATA2,
    output logic            RBUSY1,
    output logic            RBUSY2,
    input  logic            WEN,
    input  logic [AW-1:0]   WADDR,
    input  logic [XLEN-1:0] WDATA,
    input  logic            RSV_EN,
    input  logic [AW-1:0]   RSV_ADDR,
    input  logic            CLR_REQ,
    output logic            CLR_BUSY
);

    typedef enum logic {IDLE, SWEEP} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t            state, state_nxt;
    logic [AW-1:0]     idx;
    logic [XLEN-1:0]   mem [NREGS];
    logic [NREGS-1:0]  pending;

    logic wr_commit, rsv_set, byp1, byp2;

    assign wr_commit = WEN && (WADDR != '0) && (state == IDLE);
    assign rsv_set   = RSV_EN && (RSV_ADDR != '0) && (state == IDLE);
    assign byp1      = wr_commit && (WADDR == RADDR1);
    assign byp2      = wr_commit && (WADDR == RADDR2);

    // x0 is never written, but forcing zero here keeps reads independent of mem[0]
    assign RDATA1 = (RADDR1 == '0) ? '0 : (byp1 ? WDATA : mem[RADDR1]);
    assign RDATA2 = (RADDR2 == '0) ? '0 : (byp2 ? WDATA : mem[RADDR2]);
    assign RBUSY1 = (RADDR1 != '0) && pending[RADDR1] && !byp1;
    assign RBUSY2 = (RADDR2 != '0) && pending[RADDR2] && !byp2;
    assign CLR_BUSY = (state == SWEEP);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (CLR_REQ) state_nxt = SWEEP;
            SWEEP: if (idx == LAST_IDX) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && CLR_REQ)
                idx <= AW'(1);
            else if (state == SWEEP && idx != LAST_IDX)
                idx <= idx + AW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREGS; i++)
                mem[i] <= '0;
        end else if (state == SWEEP) begin
            mem[idx] <= '0;
        end else if (wr_commit) begin
            mem[WADDR] <= WDATA;
        end
    end

    // Reserve is applied after the write-back clear so a same-address reserve wins
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pending <= '0;
        end else if (state == SWEEP) begin
            pending[idx] <= 1'b0;
        end else begin
            if (wr_commit)
                pending[WADDR] <= 1'b0;
            if (rsv_set)
                pending[RSV_ADDR] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb/tb_reg_file_scoreboard.sv - randomized self-checking bench for reg_file_scoreboard
module tb_reg_file_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic [AW-1:0]   RADDR1, RADDR2, WADDR, RSV_ADDR;
    logic [XLEN-1:0] RDATA1, RDATA2, WDATA;
    logic            RBUSY1, RBUSY2, WEN, RSV_EN, CLR_REQ, CLR_BUSY;

    always #5 CLK = ~CLK;

    reg_file_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .RADDR1(RADDR1), .RADDR2(RADDR2),
        .RDATA1(RDATA1), .RDATA2(RDATA2),
        .RBUSY1(RBUSY1), .RBUSY2(RBUSY2),
        .WEN(WEN), .WADDR(WADDR), .WDATA(WDATA),
        .RSV_EN(RSV_EN), .RSV_ADDR(RSV_ADDR),
        .CLR_REQ(CLR_REQ), .CLR_BUSY(CLR_BUSY)
    );

    logic [XLEN-1:0] ref_mem [NREGS];
    logic            ref_pend [NREGS];
    int              sweep_q [$];
    int              n_cmp = 0;
    int              n_err = 0;

    task automatic check_val(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_bypass(input logic [AW-1:0] a);
        return (sweep_q.size() == 0) && WEN && (WADDR != 0) && (WADDR == a);
    endfunction

    function automatic logic [XLEN-1:0] model_rdata(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (model_bypass(a)) return WDATA;
        return ref_mem[a];
    endfunction

    function automatic logic model_busy(input logic [AW-1:0] a);
        return (a != 0) && ref_pend[a] && !model_bypass(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            ref_mem[i]  = '0;
            ref_pend[i] = 1'b0;
        end
        sweep_q.delete();
    endtask

    task automatic model_edge();
        if (sweep_q.size() != 0) begin
            int a;
            a = sweep_q.pop_front();
            ref_mem[a]  = '0;
            ref_pend[a] = 1'b0;
        end else begin
            if (WEN && WADDR != 0) begin
                ref_mem[WADDR]  = WDATA;
                ref_pend[WADDR] = 1'b0;
            end
            if (RSV_EN && RSV_ADDR != 0)
                ref_pend[RSV_ADDR] = 1'b1;
            if (CLR_REQ)
                for (int i = 1; i < NREGS; i++) sweep_q.push_back(i);
        end
    endtask

    task automatic check_model();
        check_val("rdata1", RDATA1, model_rdata(RADDR1));
        check_val("rdata2", RDATA2, model_rdata(RADDR2));
        check_val("rbusy1", XLEN'(RBUSY1), XLEN'(model_busy(RADDR1)));
        check_val("rbusy2", XLEN'(RBUSY2), XLEN'(model_busy(RADDR2)));
        check_val("clr_busy", XLEN'(CLR_BUSY), XLEN'(sweep_q.size() != 0));
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge
    task automatic tick();
        #1;
        check_model();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        WEN = 0; WADDR = '0; WDATA = '0;
        RSV_EN = 0; RSV_ADDR = '0; CLR_REQ = 0;
        RADDR1 = '0; RADDR2 = '0;
    endtask

    task automatic fill_regs();
        for (int i = 1; i < NREGS; i++) begin
            WEN = 1; WADDR = AW'(i); WDATA = $urandom() | 32'h1;
            tick();
        end
        WEN = 0;
    endtask

    int cnt;

    initial begin
        idle_inputs();
        model_reset();
        RST_N = 0;
        repeat (2) @(negedge CLK);
        #1;
        check_model();
        check_val("rst_clr_busy", XLEN'(CLR_BUSY), '0);
        @(negedge CLK);
        RST_N = 1;

        // same-cycle bypass then array read
        WEN = 1; WADDR = 5; WDATA = 32'hDEADBEEF; RADDR1 = 5;
        #1 check_val("x5_bypass", RDATA1, 32'hDEADBEEF);
        tick();
        WEN = 0;
        #1 check_val("x5_array", RDATA1, 32'hDEADBEEF);
        tick();

        // x0 ignores writes and reserves
        WEN = 1; WADDR = 0; WDATA = 32'h1234; RADDR1 = 0;
        tick();
        WEN = 0; RSV_EN = 1; RSV_ADDR = 0;
        #1 check_val("x0_read", RDATA1, '0);
        tick();
        RSV_EN = 0;
        #1 check_val("x0_busy", XLEN'(RBUSY1), '0);
        tick();

        // reserve then write-back clears busy
        RSV_EN = 1; RSV_ADDR = 7; RADDR2 = 7;
        tick();
        RSV_EN = 0;
        #1 check_val("x7_busy_set", XLEN'(RBUSY2), 1);
        tick();
        WEN = 1; WADDR = 7; WDATA = 32'h55;
        #1 check_val("x7_busy_byp", XLEN'(RBUSY2), '0);
        check_val("x7_data_byp", RDATA2, 32'h55);
        tick();
        WEN = 0;
        #1 check_val("x7_busy_after", XLEN'(RBUSY2), '0);
        tick();

        // reserve and write at the same edge: reserve wins
        RSV_EN = 1; RSV_ADDR = 9; WEN = 1; WADDR = 9; WDATA = 32'hABC; RADDR1 = 9;
        tick();
        RSV_EN = 0; WEN = 0;
        #1 check_val("x9_busy", XLEN'(RBUSY1), 1);
        check_val("x9_data", RDATA1, 32'hABC);
        tick();

        // full sweep with writes attempted throughout
        fill_regs();
        CLR_REQ = 1;
        tick();
        CLR_REQ = 0;
        cnt = 0;
        while (CLR_BUSY && cnt < 100) begin
            WEN = 1; WADDR = AW'($urandom_range(1, NREGS - 1)); WDATA = $urandom();
            RSV_EN = 1; RSV_ADDR = AW'($urandom_range(1, NREGS - 1));
            CLR_REQ = 1'($urandom_range(0, 1));
            RADDR1 = WADDR; RADDR2 = AW'($urandom_range(0, NREGS - 1));
            tick();
            cnt++;
        end
        check_val("sweep_len", XLEN'(cnt), 31);
        idle_inputs();
        for (int i = 0; i < NREGS; i++) begin
            RADDR1 = AW'(i); RADDR2 = AW'(i);
            #1 check_val("post_sweep_zero", RDATA1, '0);
            check_val("post_sweep_busy", XLEN'(RBUSY2), '0);
            tick();
        end

        // reset in the middle of a sweep
        fill_regs();
        RSV_EN = 1; RSV_ADDR = 20;
        tick();
        RSV_ADDR = 25;
        tick();
        RSV_EN = 0; CLR_REQ = 1;
        tick();
        CLR_REQ = 0;
        repeat (9) tick();
        RST_N = 0;
        model_reset();
        #1 check_val("abort_clr_busy", XLEN'(CLR_BUSY), '0);
        for (int i = 0; i < NREGS; i++) begin
            RADDR1 = AW'(i); RADDR2 = AW'(i);
            #1 check_val("abort_zero", RDATA1, '0);
            check_val("abort_busy", XLEN'(RBUSY2), '0);
        end
        @(negedge CLK);
        RST_N = 1;
        WEN = 1; WADDR = 3; WDATA = 32'h3333;
        tick();
        WEN = 0; RADDR1 = 3;
        #1 check_val("x3_after_rst", RDATA1, 32'h3333);
        tick();

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            WEN      = 1'($urandom_range(0, 1));
            WADDR    = AW'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : NREGS - 1));
            WDATA    = $urandom();
            RSV_EN   = 1'($urandom_range(0, 1));
            RSV_ADDR = AW'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : NREGS - 1));
            CLR_REQ  = ($urandom_range(0, 59) == 0);
            RADDR1   = ($urandom_range(0, 3) == 0) ? WADDR : AW'($urandom_range(0, 7));
            RADDR2   = ($urandom_range(0, 3) == 0) ? RSV_ADDR : AW'($urandom_range(0, NREGS - 1));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_scoreboard.md
REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001: Parameter XLEN, default 32, register data width in bits.
REQ-002: Parameter NREGS, default 32, number of architectural registers; SHALL be a power of two and at least 4.
REQ-003: Parameter AW, default $clog2(NREGS), register address width.
REQ-004: CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-005: RST_N  input  1  reset, asynchronous assert, active-low.
REQ-006: RADDR1, RADDR2  input  AW  read-port addresses.
REQ-007: RDATA1, RDATA2  output  XLEN  read data.
REQ-008: RBUSY1, RBUSY2  output  1  pending-write flag for the addressed register.
REQ-009: WEN  input  1  write-back enable.
REQ-010: WADDR  input  AW  write-back address.
REQ-011: WDATA  input  XLEN  write-back data.
REQ-012: RSV_EN  input  1  reserve request: marks a register as having a write in flight.
REQ-013: RSV_ADDR  input  AW  reserve address.
REQ-014: CLR_REQ  input  1  request for a synchronous sweep that zeroes all registers.
REQ-015: CLR_BUSY  output  1  high while the sweep is in progress.

Function
REQ-016: Register 0 SHALL always read 0, SHALL ignore writes, and SHALL never report busy.
REQ-017: Reads SHALL be combinational from the array, with no clock latency.
REQ-018: Bypass: when WEN=1, WADDR=RADDRn, WADDR!=0 and CLR_BUSY=0, RDATAn SHALL equal WDATA in that same cycle.
REQ-019: A write SHALL commit at the rising edge when WEN=1, WADDR!=0 and CLR_BUSY=0; otherwise the array is unchanged.
REQ-020: Scoreboard: one pending bit per register; RSV_EN=1 with RSV_ADDR!=0 and CLR_BUSY=0 SHALL set pending[RSV_ADDR] at the edge.
REQ-021: A committed write SHALL clear pending[WADDR] at the edge.
REQ-022: When a reserve and a write target the same address at the same edge, the set SHALL win (pending=1).
REQ-023: RBUSYn SHALL equal pending[RADDRn] AND NOT (bypass active on port n); RBUSYn SHALL be 0 for address 0.
REQ-024: Clear FSM states: IDLE and SWEEP; IDLE SHALL go to SWEEP when CLR_REQ=1, loading index 1.
REQ-025: In SWEEP, each edge SHALL write 0 to mem[index] and clear pending[index], then increment the index.
REQ-026: SWEEP SHALL return to IDLE on the edge that clears index NREGS-1; the sweep lasts exactly NREGS-1 cycles.
REQ-027: CLR_BUSY SHALL be 1 exactly while the state is SWEEP, with a registered output.
REQ-028: In SWEEP, WEN, RSV_EN and CLR_REQ SHALL be ignored, bypass SHALL be disabled, and reads SHALL return current array contents.
REQ-029: The index counter SHALL be AW bits wide and SHALL NOT wrap to 0 during a sweep.

Reset
REQ-030: While RST_N=0, asynchronously: all registers 0, all pending bits 0, FSM in IDLE, index 0, CLR_BUSY=0.
REQ-031: RST_N asserted mid-sweep SHALL abort the sweep immediately, with the REQ-030 values.
REQ-032: After RST_N deasserts, the first active edge SHALL behave as a normal IDLE cycle.

Verification
REQ-033: Write x5=0xDEADBEEF and read it on port 1 in the same cycle -> RDATA1=0xDEADBEEF via bypass; the next cycle it reads from the array with the same value.
REQ-034: Write x0=0x1234, then read x0 -> RDATA=0 and RBUSY=0; reserve x0 -> RBUSY stays 0.
REQ-035: Reserve x7, hold RADDR2=7 -> RBUSY2=1 from the next cycle; WEN x7=0x55 -> RBUSY2=0 in that cycle, and pending stays clear afterwards.
REQ-036: Reserve and write x9 at the same edge -> RBUSY for x9=1 afterwards.
REQ-037: Fill x1..x31 with nonzero values and pulse CLR_REQ -> CLR_BUSY=1 for 31 cycles; writes during the sweep are dropped; all reads are 0 afterwards.
REQ-038: Assert RST_N=0 at sweep cycle 10 -> CLR_BUSY=0 and all registers and pending bits 0 immediately; after release, a write to x3 commits normally.
